vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 100 MHz; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; one clock, asynchronous, active-high.
REQ-003 SHALL have port: hsync  output  1  horizontal sync, active-low, registered.
REQ-004 SHALL have port: vsync  output  1  vertical sync, active-low, registered.
REQ-005 SHALL have port: video_on  output  1  high while the current pixel is in the 640x480 visible area.
REQ-006 SHALL have port: p_tick  output  1  pixel-rate enable, high 1 clk of every 4 (25 MHz).
REQ-007 SHALL have port: pixel_x  output  10  current column, equal to h_count.
REQ-008 SHALL have port: pixel_y  output  10  current row, equal to v_count.
REQ-009 SHALL have port: frame_tick  output  1  end-of-frame pulse; present only per REQ-027.

Function
REQ-010 SHALL hold a 2-bit divider div counting 0,1,2,3,0… every clk; p_tick = (div==3), decoded from the register.
REQ-011 SHALL hold a 10-bit h_count that advances only on clk edges where div==3: 0..799, then wraps to 0.
REQ-012 SHALL hold a 10-bit v_count that advances only on edges where div==3 and h_count==799: 0..524, then wraps to 0.
REQ-013 SHALL hold every h_count value for exactly 4 clks; one line = 3200 clks; one frame = 1,680,000 clks.
REQ-014 SHALL use horizontal timing of 640 visible, 16 front porch, 96 sync, 48 back porch (total 800).
REQ-015 SHALL use vertical timing of 480 visible, 10 front porch, 2 sync, 33 back porch (total 525).
REQ-016 SHALL drive hsync low exactly while h_count is in 656..751 inclusive, and high otherwise.
REQ-017 SHALL drive vsync low exactly while v_count is in 490..491 inclusive, and high otherwise.
REQ-018 SHALL register hsync/vsync from the next-state counter values on the same edge, so the syncs never lag the counters.
REQ-019 SHALL compute video_on = (h_count<640) AND (v_count<480), combinationally from the registered counters.
REQ-020 SHALL handle the simultaneous h_count and v_count wrap (799/524 -> 0/0) in a single edge, with no intermediate value.
REQ-021 SHALL never let the counters reach out-of-range values (h>799, v>524), including after reset.

Reset
REQ-022 SHALL, while rst=1, force div=0, h_count=0, v_count=0, hsync=1, vsync=1, and make p_tick=0, independent of clk.
REQ-023 SHALL produce video_on=1, pixel_x=0 and pixel_y=0 during reset, derived from counters at 0.
REQ-024 SHALL, on rst asserted mid-frame (including mid-sync pulse), immediately return all state to REQ-022 values and deassert any active sync.
REQ-025 SHALL put out its first p_tick on the 4th rising edge after rst deasserts (div 0->1->2->3).
REQ-026 SHALL drive frame_tick to 0 during reset.

Configuration
REQ-027 SHALL, with macro VGA_SYNC_FRAME_TICK_EN defined, provide frame_tick = p_tick AND h_count==799 AND v_count==524 (one clk per frame).
REQ-028 SHALL, without VGA_SYNC_FRAME_TICK_EN, omit the frame_tick port and logic; all other behaviour is identical.

Verification
REQ-029 SHALL verify reset values: assert rst for 3 clks, check hsync=1, vsync=1, video_on=1, pixel_x=0, pixel_y=0, p_tick=0; release rst, check first p_tick on the 4th edge.
REQ-030 SHALL verify p_tick and horizontal timing: run 2 lines, check p_tick period is 4 clks, hsync falls when pixel_x becomes 656, hsync rises when pixel_x becomes 752, and video_on falls at pixel_x=640.
REQ-031 SHALL verify frame timing: run 1 full frame, check vsync low only for pixel_y 490..491 (6400 clks), next frame starts after 1,680,000 clks, and pixel_x/pixel_y never exceed 799/524.
REQ-032 SHALL verify the wrap: at pixel_x=799, pixel_y=524 with div==3, the next edge gives 0/0, video_on=1 and hsync=vsync=1.
REQ-033 SHALL verify reset mid-operation: assert rst asynchronously between edges at pixel_y=491 during the vsync pulse, check vsync=1 and counters=0 before the next clk edge.
REQ-034 SHALL verify frame_tick: with VGA_SYNC_FRAME_TICK_EN, count exactly 1 single-clk frame_tick per 1,680,000 clks, coincident with p_tick at 799/524; without the macro, the build elaborates with no frame_tick port.

Source files
------------

// File: rtl/vga_sync.sv
`timescale 1ns/1ps
// vga_sync: 640x480@60 timing generator on a 100 MHz clock with a /4 pixel enable.
// Latency: hsync/vsync are registered from next-state counters, so they align with pixel_x/pixel_y.
// Backpressure: none; free-running. Optional frame_tick port when VGA_SYNC_FRAME_TICK_EN is defined.
module vga_sync (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  // Horizontal timing in pixels: visible, front porch, sync, back porch.
  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_SYNC0 = 10'd656;
  localparam logic [9:0] H_SYNC1 = 10'd751;
  localparam logic [9:0] H_LAST  = 10'd799;
  // Vertical timing in lines.
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_SYNC0 = 10'd490;
  localparam logic [9:0] V_SYNC1 = 10'd491;
  localparam logic [9:0] V_LAST  = 10'd524;

  logic [1:0] r_div;
  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       r_hsync;
  logic       r_vsync;

  logic       w_tick;
  logic       w_h_end;
  logic       w_v_end;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hsync_next;
  logic       w_vsync_next;

  assign w_tick  = (r_div == 2'd3);
  // >= rather than == so a corrupted counter snaps back into range instead of running on.
  assign w_h_end = (r_h_count >= H_LAST);
  assign w_v_end = (r_v_count >= V_LAST);

  // Next-state counters; the h/v wrap at end of frame happens in one step.
  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (w_tick) begin
      if (w_h_end) begin
        w_h_next = 10'd0;
        w_v_next = w_v_end ? 10'd0 : (r_v_count + 10'd1);
      end else begin
        w_h_next = r_h_count + 10'd1;
      end
    end
  end

  // Syncs decoded from next-state counters so the registered pulse lines up with the counters.
  always_comb begin
    w_hsync_next = ~((w_h_next >= H_SYNC0) && (w_h_next <= H_SYNC1));
    w_vsync_next = ~((w_v_next >= V_SYNC0) && (w_v_next <= V_SYNC1));
  end

  // Divider, counters and sync registers; reset parks everything at top-left with syncs idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= 2'd0;
      r_h_count <= 10'd0;
      r_v_count <= 10'd0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
    end else begin
      r_div     <= r_div + 2'd1;
      r_h_count <= w_h_next;
      r_v_count <= w_v_next;
      r_hsync   <= w_hsync_next;
      r_vsync   <= w_vsync_next;
    end
  end

  assign p_tick   = w_tick;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign pixel_x  = r_h_count;
  assign pixel_y  = r_v_count;
  assign video_on = (r_h_count < H_VIS) && (r_v_count < V_VIS);

`ifdef VGA_SYNC_FRAME_TICK_EN
  // One clk per frame: the pixel enable that retires the last pixel of the last line.
  assign frame_tick = w_tick && (r_h_count == H_LAST) && (r_v_count == V_LAST);
`endif

endmodule

// File: tb/tb_vga_sync.sv
`timescale 1ns/1ps
module tb_vga_sync;

  logic       clk;
  logic       rst;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       frame_tick;
`endif

  vga_sync dut (
`ifdef VGA_SYNC_FRAME_TICK_EN
    .frame_tick (frame_tick),
`endif
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .p_tick     (p_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a frame is one linear sequence of 420000 pixels, each lasting 4 clks.
  int m_phase;
  int m_pix;
  int m_seen;
  int jump_seq = 0;
  int jump_row = 0;

  always @(posedge clk or posedge rst) begin : model
    int pix;
    if (rst) begin
      m_phase <= 0;
      m_pix   <= 0;
      m_seen  <= jump_seq;
    end else begin
      pix = m_pix;
      if (jump_seq != m_seen) pix = jump_row * 800 + (m_pix % 800);
      if (m_phase == 3) pix = (pix + 1) % 420000;
      m_pix   <= pix;
      m_phase <= (m_phase + 1) % 4;
      m_seen  <= jump_seq;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int h, v, e_tick;
    h = m_pix % 800;
    v = m_pix / 800;
    e_tick = (m_phase == 3) ? 1 : 0;
    check("p_tick",   int'(p_tick),   e_tick);
    check("pixel_x",  int'(pixel_x),  h);
    check("pixel_y",  int'(pixel_y),  v);
    check("hsync",    int'(hsync),    (h >= 656 && h <= 751) ? 0 : 1);
    check("vsync",    int'(vsync),    (v >= 490 && v <= 491) ? 0 : 1);
    check("video_on", int'(video_on), (h < 640 && v < 480) ? 1 : 0);
    check("x_range",  int'(pixel_x <= 10'd799), 1);
    check("y_range",  int'(pixel_y <= 10'd524), 1);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("frame_tick", int'(frame_tick), (e_tick == 1 && m_pix == 419999) ? 1 : 0);
`endif
  endtask

  // Called at a negedge: moves the DUT row counter and tells the model, keeping column and phase.
  task automatic jump_to_row(input int row);
    logic [9:0] r;
    r = 10'(row);
    force dut.r_v_count = r;
    jump_row = row;
    jump_seq++;
    #1;
    release dut.r_v_count;
  endtask

  initial begin
    int cyc, last_tick, hfalls, vlow, wraps, ftick;
    logic ph, pv, pvid;
    logic [9:0] px, py;
    bit found;

    // Reset held for 3 clks
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hsync",    int'(hsync),    1);
    check("rst_vsync",    int'(vsync),    1);
    check("rst_video_on", int'(video_on), 1);
    check("rst_pixel_x",  int'(pixel_x),  0);
    check("rst_pixel_y",  int'(pixel_y),  0);
    check("rst_p_tick",   int'(p_tick),   0);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("rst_frame_tick", int'(frame_tick), 0);
`endif
    rst = 1'b0;

    // Divider ramps 0->1->2->3: p_tick visible after the 3rd edge, consumed on the 4th
    @(negedge clk); compare_all(); check("edge1_p_tick", int'(p_tick), 0);
    @(negedge clk); compare_all(); check("edge2_p_tick", int'(p_tick), 0);
    @(negedge clk); compare_all(); check("edge3_p_tick", int'(p_tick), 1);
    check("edge3_pixel_x", int'(pixel_x), 0);
    @(negedge clk); compare_all(); check("edge4_pixel_x", int'(pixel_x), 1);
    check("edge4_p_tick", int'(p_tick), 0);

    // Two lines of horizontal timing
    cyc = 0; last_tick = -1; hfalls = 0;
    ph = hsync; pvid = video_on;
    repeat (6400) begin
      @(negedge clk);
      cyc++;
      compare_all();
      if (p_tick) begin
        if (last_tick >= 0) check("p_tick_period", cyc - last_tick, 4);
        last_tick = cyc;
      end
      if (ph && !hsync) begin
        hfalls++;
        check("hsync_fall_x", int'(pixel_x), 656);
      end
      if (!ph && hsync) check("hsync_rise_x", int'(pixel_x), 752);
      if (pvid && !video_on) check("video_off_x", int'(pixel_x), 640);
      ph = hsync; pvid = video_on;
    end
    check("hsync_falls_2lines", hfalls, 2);

    // Vertical sync window: rows 488..492
    jump_to_row(488);
    vlow = 0; pv = vsync;
    repeat (16000) begin
      @(negedge clk);
      compare_all();
      if (!vsync) vlow++;
      if (pv && !vsync) begin
        check("vsync_fall_y", int'(pixel_y), 490);
        check("vsync_fall_x", int'(pixel_x), 0);
      end
      if (!pv && vsync) check("vsync_rise_y", int'(pixel_y), 492);
      pv = vsync;
    end
    check("vsync_low_clks", vlow, 6400);

    // End-of-frame wrap
    jump_to_row(522);
    wraps = 0; ftick = 0; px = pixel_x; py = pixel_y;
    repeat (9608) begin
      @(negedge clk);
      compare_all();
`ifdef VGA_SYNC_FRAME_TICK_EN
      if (frame_tick) begin
        ftick++;
        check("frame_tick_p_tick", int'(p_tick), 1);
      end
`endif
      if (px == 10'd799 && py == 10'd524 && pixel_x != 10'd799) begin
        wraps++;
        check("wrap_x", int'(pixel_x), 0);
        check("wrap_y", int'(pixel_y), 0);
        check("wrap_video_on", int'(video_on), 1);
        check("wrap_hsync", int'(hsync), 1);
        check("wrap_vsync", int'(vsync), 1);
      end
      px = pixel_x; py = pixel_y;
    end
    check("wrap_count", wraps, 1);
`ifdef VGA_SYNC_FRAME_TICK_EN
    check("frame_tick_count", ftick, 1);
`endif

    // Asynchronous reset in the middle of the vsync pulse
    jump_to_row(489);
    found = 0;
    for (int k = 0; k < 12000 && !found; k++) begin
      @(negedge clk);
      compare_all();
      if (m_pix == 491 * 800 + 300) found = 1;
    end
    check("reach_row491", int'(found), 1);
    check("pre_rst_vsync", int'(vsync), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_vsync",    int'(vsync),    1);
    check("arst_hsync",    int'(hsync),    1);
    check("arst_pixel_x",  int'(pixel_x),  0);
    check("arst_pixel_y",  int'(pixel_y),  0);
    check("arst_p_tick",   int'(p_tick),   0);
    check("arst_video_on", int'(video_on), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      compare_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
